cpu_ctrl_seq: RTL and testbench

Multi-cycle control sequencer for the 8-bit CPU, on the driving side of the ALU interface. It fetches and decodes instructions, owns the PC, the zero flag and a 4×8 register file, and presents operands and an operation code to the ALU. It consumes the ALU result and zero flag, writes back results, and performs load/store through a req/ack data-memory port.

---
 rtl/cpu_pkg.sv | 55 +++++
 rtl/reg_file4x8.sv | 31 +++
 rtl/cpu_ctrl_seq.sv | 138 +++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, ALU codes, sequencer states and instruction layout.
// Used by the control sequencer, the ALU and testbenches.
package cpu_pkg;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned REG_AW   = 2;
  localparam int unsigned OPC_W    = 3;
  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned OFF_W    = 5;

  typedef enum logic [OPC_W-1:0] {
    OPC_ADD   = 3'b000,
    OPC_SUB   = 3'b001,
    OPC_AND   = 3'b010,
    OPC_LOAD  = 3'b011,
    OPC_STORE = 3'b100,
    OPC_BEQZ  = 3'b101,
    OPC_LDI   = 3'b110,
    OPC_HALT  = 3'b111
  } opcode_e;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_AND    = 3'b010,
    ALU_PASS_B = 3'b011
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_IMM    = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  // Instruction byte layout: [7:5] opcode, [4:3] rd, [2:1] rs, [0] spare.
  typedef struct packed {
    opcode_e           opc;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic              spare;
  } instr_t;

  // BEQZ reuses [4:0] as a signed offset, sign-extended to address width.
  function automatic logic [ADDR_W-1:0] branch_off(input instr_t ins);
    logic [OFF_W-1:0] off;
    off = {ins.rd, ins.rs, ins.spare};
    return {{(ADDR_W-OFF_W){off[OFF_W-1]}}, off};
  endfunction

endpackage

// File: rtl/reg_file4x8.sv
// 4x8 register file: two asynchronous read ports, one synchronous write port, synchronous clear.
module reg_file4x8
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data_c,
  input  logic [REG_AW-1:0] rs_addr,
  output logic [DATA_W-1:0] rs_data_c,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  assign rd_data_c = regs_q[rd_addr];
  assign rs_data_c = regs_q[rs_addr];

endmodule

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer: fetch/decode/execute FSM owning PC, IR, zero flag and the
// register file; drives the external ALU and the instruction/data memory handshakes.
module cpu_ctrl_seq
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [DATA_W-1:0]   imem_rdata,
  input  logic                imem_ack,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  input  logic [DATA_W-1:0]   dmem_rdata,
  input  logic                dmem_ack,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]   alu_result,
  input  logic                alu_zero,
  output logic                halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  instr_t            ir_q, ir_d;
  logic              z_q, z_d;

  logic              rf_we;
  logic [DATA_W-1:0] rf_rd_data;
  logic [DATA_W-1:0] rf_rs_data;
  alu_op_e           alu_op_c;
  logic [DATA_W-1:0] alu_b_c;

  reg_file4x8 u_rf (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (ir_q.rd),
    .rd_data_c (rf_rd_data),
    .rs_addr   (ir_q.rs),
    .rs_data_c (rf_rs_data),
    .we        (rf_we),
    .waddr     (ir_q.rd),
    .wdata     (alu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
    end
  end

  // Next state, architectural updates and ALU steering.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    z_d      = z_q;
    rf_we    = 1'b0;
    alu_op_c = ALU_ADD;
    alu_b_c  = rf_rs_data;

    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          ir_d    = instr_t'(imem_rdata);
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (ir_q.opc)
          OPC_ADD, OPC_SUB, OPC_AND, OPC_BEQZ: state_d = ST_EXEC;
          OPC_LOAD, OPC_STORE:                 state_d = ST_MEM;
          OPC_LDI:                             state_d = ST_IMM;
          default:                             state_d = ST_HALT;
        endcase
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (ir_q.opc)
          OPC_SUB: alu_op_c = ALU_SUB;
          OPC_AND: alu_op_c = ALU_AND;
          default: alu_op_c = ALU_ADD;
        endcase
        if (ir_q.opc == OPC_BEQZ) begin
          if (z_q) pc_d = pc_q + branch_off(ir_q);
        end else begin
          rf_we = 1'b1;
          z_d   = alu_zero;
        end
      end
      ST_MEM: begin
        if (dmem_ack) begin
          if (ir_q.opc == OPC_LOAD) begin
            alu_op_c = ALU_PASS_B;
            alu_b_c  = dmem_rdata;
            rf_we    = 1'b1;
          end
          state_d = ST_FETCH;
        end
      end
      ST_IMM: begin
        if (imem_ack) begin
          alu_op_c = ALU_PASS_B;
          alu_b_c  = imem_rdata;
          rf_we    = 1'b1;
          pc_d     = pc_q + ADDR_W'(1);
          state_d  = ST_FETCH;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  // Outputs decode from state and are held at zero throughout reset.
  assign imem_req   = !rst && ((state_q == ST_FETCH) || (state_q == ST_IMM));
  assign imem_addr  = rst ? '0 : pc_q;
  assign dmem_req   = !rst && (state_q == ST_MEM);
  assign dmem_we    = dmem_req && (ir_q.opc == OPC_STORE);
  assign dmem_addr  = rst ? '0 : rf_rs_data;
  assign dmem_wdata = rst ? '0 : rf_rd_data;
  assign alu_a      = rst ? '0 : rf_rd_data;
  assign alu_b      = rst ? '0 : alu_b_c;
  assign alu_op     = rst ? '0 : alu_op_c;
  assign halted     = !rst && (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: bench-side ALU and memories, cycle-exact program checks.
module tb_cpu_ctrl_seq;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       imem_req, imem_ack;
  logic [7:0] imem_addr, imem_rdata;
  logic       dmem_req, dmem_we, dmem_ack;
  logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_op;
  logic       alu_zero;
  logic       halted;

  int n_cmp = 0;
  int n_bad = 0;
  int imem_wait = 0;
  int dmem_wait = 0;
  int icnt, dcnt;

  logic [7:0] imem [256];
  logic [7:0] dmem [256];

  cpu_ctrl_seq dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Reference ALU.
  always_comb begin
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_b;
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  // Memories with programmable wait states.
  assign imem_ack   = imem_req && (icnt >= imem_wait);
  assign dmem_ack   = dmem_req && (dcnt >= dmem_wait);
  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];

  always_ff @(posedge clk) begin
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = 8'hE0;
  endtask

  // Hold reset for two edges, then release; returns in cycle 0 of the new run.
  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_imem();

    // Program 1: LDI r1,5; LDI r2,5; SUB r1,r2; STORE r1->[r2]; BEQZ +2
    imem[0] = 8'hC8; imem[1] = 8'h05; imem[2] = 8'hD0; imem[3] = 8'h05;
    imem[4] = 8'h2C; imem[5] = 8'h8C; imem[6] = 8'hA2;
    ticks(2);
    chk("rst_imem_req", 8'(imem_req), 8'h00);
    chk("rst_dmem_req", 8'(dmem_req), 8'h00);
    chk("rst_halted",   8'(halted),   8'h00);
    chk("rst_alu_op",   8'(alu_op),   8'h00);
    rst = 1'b0;
    #1;
    chk("p1_c0_req",  8'(imem_req), 8'h01);
    chk("p1_c0_addr", imem_addr,    8'h00);
    ticks(7);
    chk("p1_decode_op", 8'(alu_op), 8'h00);
    tick();
    chk("p1_sub_op", 8'(alu_op), 8'h01);
    chk("p1_sub_a",  alu_a,      8'h05);
    chk("p1_sub_b",  alu_b,      8'h05);
    tick();
    chk("p1_c9_req",  8'(imem_req), 8'h01);
    chk("p1_c9_addr", imem_addr,    8'h05);
    ticks(2);
    chk("p1_st_req",   {6'b0, dmem_req, dmem_we}, 8'h03);
    chk("p1_st_addr",  dmem_addr,  8'h05);
    chk("p1_st_wdata", dmem_wdata, 8'h00);
    ticks(4);
    chk("p1_beqz_taken", imem_addr, 8'h09);

    // Program 2: LDI r0,FF; LDI r3,01; ADD r0,r3; STORE r0->[r2]; BEQZ +2
    clear_imem();
    imem[0] = 8'hC0; imem[1] = 8'hFF; imem[2] = 8'hD8; imem[3] = 8'h01;
    imem[4] = 8'h06; imem[5] = 8'h84; imem[6] = 8'hA2;
    do_reset();
    ticks(8);
    chk("p2_add_op", 8'(alu_op), 8'h00);
    chk("p2_add_a",  alu_a,      8'hFF);
    chk("p2_add_b",  alu_b,      8'h01);
    ticks(3);
    chk("p2_st_addr",  dmem_addr,  8'h00);
    chk("p2_st_wdata", dmem_wdata, 8'h00);
    ticks(4);
    chk("p2_beqz_taken", imem_addr, 8'h09);

    // Program 3: BEQZ -3 (z=0); SUB r0,r0; BEQZ -3 -> 0; BEQZ -3 (z=1) -> FE; HALT
    clear_imem();
    imem[0] = 8'hBD; imem[1] = 8'h20; imem[2] = 8'hBD;
    do_reset();
    ticks(3);
    chk("p3_not_taken", imem_addr, 8'h01);
    ticks(2);
    chk("p3_sub_op", 8'(alu_op), 8'h01);
    ticks(4);
    chk("p3_back_to_0", imem_addr, 8'h00);
    ticks(3);
    chk("p3_wrap_fe", imem_addr, 8'hFE);
    ticks(2);
    chk("p3_halted", 8'(halted), 8'h01);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("p3_halt_quiet", {5'b0, halted, imem_req, dmem_req}, 8'h04);
    end
    rst = 1'b1;
    #1;
    chk("p3_rst_halted", 8'(halted), 8'h00);
    tick();
    rst = 1'b0;
    #1;
    chk("p3_restart", {7'b0, imem_req}, 8'h01);
    chk("p3_restart_addr", imem_addr, 8'h00);

    // Program 4: LDI r1,40; LDI r2,A5; STORE r2->[r1]; LOAD r3<-[r1]; STORE r3->[r1]; 3 dmem waits
    clear_imem();
    imem[0] = 8'hC8; imem[1] = 8'h40; imem[2] = 8'hD0; imem[3] = 8'hA5;
    imem[4] = 8'h92; imem[5] = 8'h7A; imem[6] = 8'h9A;
    dmem_wait = 3;
    do_reset();
    ticks(8);
    for (int i = 0; i < 4; i++) begin
      chk("p4_st_req",   {5'b0, dmem_req, dmem_we, dmem_ack}, (i == 3) ? 8'h07 : 8'h06);
      chk("p4_st_addr",  dmem_addr,  8'h40);
      chk("p4_st_wdata", dmem_wdata, 8'hA5);
      tick();
    end
    chk("p4_mem_40", dmem[8'h40], 8'hA5);
    ticks(5);
    chk("p4_ld_ack", {6'b0, dmem_ack, dmem_we}, 8'h02);
    chk("p4_ld_op",  8'(alu_op), 8'h03);
    chk("p4_ld_b",   alu_b,      8'hA5);
    ticks(3);
    chk("p4_st2_wdata", dmem_wdata, 8'hA5);
    dmem_wait = 0;

    // Program 5: reset during a stalled fetch clears PC, regs and z
    clear_imem();
    imem[0] = 8'h20; imem[1] = 8'hC8; imem[2] = 8'h77;
    do_reset();
    ticks(6);
    imem_wait = 1000;
    #1;
    chk("p5_stall_addr", imem_addr, 8'h03);
    tick();
    chk("p5_stall_req", 8'(imem_req), 8'h01);
    clear_imem();
    imem[0] = 8'hA5; imem[1] = 8'h8A;
    rst = 1'b1;
    #1;
    chk("p5_rst_req",  8'(imem_req), 8'h00);
    chk("p5_rst_addr", imem_addr,    8'h00);
    tick();
    imem_wait = 0;
    rst = 1'b0;
    #1;
    chk("p5_c0_addr", imem_addr, 8'h00);
    ticks(3);
    chk("p5_z_clear", imem_addr, 8'h01);
    ticks(2);
    chk("p5_r1_addr",  dmem_addr,  8'h00);
    chk("p5_r1_wdata", dmem_wdata, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
